// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a big-endian, word-port data memory.
// Sub-word stores use read-modify-write; faulting requests skip the memory.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, RD, WR, RMW_RD, RMW_WR, RESP
    } state_t;

    localparam logic [31:0] LastBase = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;

    logic [31:0] base;
    logic        bad;
    logic [4:0]  sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val;
    logic [31:0] mask;
    logic [31:0] merged;

    always_comb begin
        base = {req_addr[31:2], 2'b00};
        bad  = (req_size == 2'b11)
            || (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            || (base > LastBase);
    end

    // Offset 0 is the most significant lane, so shift = (3 - offset) * 8.
    always_comb begin
        sh = '0;
        unique case (size_q)
            2'b00:   sh = {~off_q, 3'b000};
            2'b01:   sh = {~off_q[1], 4'b0000};
            default: sh = '0;
        endcase
    end

    always_comb begin
        lane_b = 8'(mem_rdata >> sh);
        lane_h = 16'(mem_rdata >> sh);
        ld_val = mem_rdata;
        if (size_q == 2'b00) begin
            ld_val = {{24{lane_b[7] & ~uns_q}}, lane_b};
        end else if (size_q == 2'b01) begin
            ld_val = {{16{lane_h[15] & ~uns_q}}, lane_h};
        end
        mask   = (size_q == 2'b00) ? (32'hFF << sh) : (32'hFFFF << sh);
        merged = (merge_q & ~mask) | ((wdata_q << sh) & mask);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        size_d     = size_q;
        off_d      = off_q;
        uns_d      = uns_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_error = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = base;
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = bad;
                    if (bad) begin
                        state_d = RESP;
                    end else if (!req_write) begin
                        state_d = RD;
                    end else if (req_size == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD: begin
                mem_addr = addr_q;
                mem_read = 1'b1;
                rdata_d  = ld_val;
                state_d  = RESP;
            end
            WR: begin
                mem_addr  = addr_q;
                mem_write = 1'b1;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RMW_RD: begin
                mem_addr = addr_q;
                mem_read = 1'b1;
                merge_d  = mem_rdata;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                mem_addr  = addr_q;
                mem_write = 1'b1;
                mem_wdata = merged;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_error = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 10-word big-endian memory.
// Each task drives one scenario and checks its own expected values.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:9];
    logic        mem_init;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] o_rdata, o_waddr, o_wword, o_a0;
    logic        o_err, o_both, o_moved, o_rdy_hi, o_rdy_req, o_rdy_after, o_seen;
    int          o_lat, o_nrd, o_nwr, o_rd_c, o_wr_c;

    load_store_unit #(.MEM_BYTES(40)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr[31:2] < 10) ? mem[mem_addr[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 10; i++) mem[i] <= 32'h0000_0001;
        end else if (mem_write && mem_addr[31:2] < 10) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        o_rdy_req    = req_ready;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_size  = 2'b10;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'h5555_5555;
        o_lat = 99; o_nrd = 0; o_nwr = 0; o_rd_c = 0; o_wr_c = 0;
        o_both = 0; o_moved = 0; o_rdy_hi = 0; o_seen = 0;
        o_rdata = 32'hx; o_err = 1'bx; o_waddr = 32'hx; o_wword = 32'hx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_read) begin
                o_nrd++;
                if (o_rd_c == 0) o_rd_c = c;
            end
            if (mem_write) begin
                o_nwr++;
                if (o_wr_c == 0) o_wr_c = c;
                o_waddr = mem_addr;
                o_wword = mem_wdata;
            end
            if (mem_read && mem_write) o_both = 1;
            if (req_ready) o_rdy_hi = 1;
            if (mem_read || mem_write) begin
                if (!o_seen) begin
                    o_a0 = mem_addr;
                    o_seen = 1;
                end else if (mem_addr !== o_a0) begin
                    o_moved = 1;
                end
            end
            if (resp_valid) begin
                o_rdata = resp_rdata;
                o_err   = resp_error;
                o_lat   = c;
                break;
            end
        end
        @(negedge clk);
        o_rdy_after = req_ready && !resp_valid;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
        n_cmp++; if (resp_error !== 1'b0) begin n_bad++; $display("FAIL rst_error got %b exp 0", resp_error); end
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL rst_mem_rw got %b exp 00", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        rst_n = 1'b1;
        mem_init = 1'b0;
    endtask

    task automatic test_load_word;
        issue(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        n_cmp++; if (o_rdy_req !== 1'b1) begin n_bad++; $display("FAIL ldw_ready got %b exp 1", o_rdy_req); end
        n_cmp++; if (o_rdata !== 32'h1) begin n_bad++; $display("FAIL ldw_rdata got %h exp 00000001", o_rdata); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL ldw_err got %b exp 0", o_err); end
        n_cmp++; if (o_lat !== 2) begin n_bad++; $display("FAIL ldw_latency got %0d exp 2", o_lat); end
        n_cmp++; if (o_nrd !== 1 || o_nwr !== 0) begin n_bad++; $display("FAIL ldw_mem_ops got rd=%0d wr=%0d exp rd=1 wr=0", o_nrd, o_nwr); end
        n_cmp++; if (o_rdy_hi !== 1'b0) begin n_bad++; $display("FAIL ldw_ready_busy got %b exp 0", o_rdy_hi); end
        n_cmp++; if (o_rdy_after !== 1'b1) begin n_bad++; $display("FAIL ldw_ready_after got %b exp 1", o_rdy_after); end
    endtask

    task automatic test_store_byte;
        issue(1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_00AB);
        n_cmp++; if (o_nrd !== 1 || o_nwr !== 1) begin n_bad++; $display("FAIL stb_mem_ops got rd=%0d wr=%0d exp rd=1 wr=1", o_nrd, o_nwr); end
        n_cmp++; if (!(o_rd_c < o_wr_c)) begin n_bad++; $display("FAIL stb_order got rd@%0d wr@%0d exp rd before wr", o_rd_c, o_wr_c); end
        n_cmp++; if (o_waddr !== 32'd4) begin n_bad++; $display("FAIL stb_addr got %h exp 00000004", o_waddr); end
        n_cmp++; if (o_wword !== 32'h00AB_0001) begin n_bad++; $display("FAIL stb_wdata got %h exp 00ab0001", o_wword); end
        n_cmp++; if (o_lat !== 3) begin n_bad++; $display("FAIL stb_latency got %0d exp 3", o_lat); end
        n_cmp++; if (o_err !== 1'b0 || o_rdata !== 32'h0) begin n_bad++; $display("FAIL stb_resp got err=%b rdata=%h exp err=0 rdata=0", o_err, o_rdata); end
        n_cmp++; if (o_both !== 1'b0 || o_moved !== 1'b0) begin n_bad++; $display("FAIL stb_bus got both=%b moved=%b exp 0 0", o_both, o_moved); end
    endtask

    task automatic test_subword_loads;
        logic        wr_t [0:6];
        logic [1:0]  sz_t [0:6];
        logic        un_t [0:6];
        logic [31:0] a_t  [0:6];
        logic [31:0] wd_t [0:6];
        logic [31:0] ex_t [0:6];
        wr_t = '{0, 0, 0, 0, 1, 0, 0};
        sz_t = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10};
        un_t = '{0, 1, 1, 0, 0, 0, 0};
        a_t  = '{32'd5, 32'd5, 32'd4, 32'd4, 32'd12, 32'd12, 32'd12};
        wd_t = '{0, 0, 0, 0, 32'h0000_8001, 0, 0};
        ex_t = '{32'hFFFF_FFAB, 32'h0000_00AB, 32'h0000_00AB, 32'h0,
                 32'h0, 32'hFFFF_8001, 32'h8001_0001};
        for (int i = 0; i < 7; i++) begin
            issue(wr_t[i], sz_t[i], un_t[i], a_t[i], wd_t[i]);
            n_cmp++;
            if (o_rdata !== ex_t[i] || o_err !== 1'b0) begin
                n_bad++;
                $display("FAIL subword[%0d] got rdata=%h err=%b exp rdata=%h err=0", i, o_rdata, o_err, ex_t[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic        wr_t [0:4];
        logic [1:0]  sz_t [0:4];
        logic [31:0] a_t  [0:4];
        wr_t = '{0, 1, 0, 0, 1};
        sz_t = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
        a_t  = '{32'd3, 32'd6, 32'd0, 32'd40, 32'd41};
        for (int i = 0; i < 5; i++) begin
            issue(wr_t[i], sz_t[i], 1'b0, a_t[i], 32'hFFFF_FFFF);
            n_cmp++;
            if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_lat !== 1) begin
                n_bad++;
                $display("FAIL err[%0d] got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=1", i, o_err, o_rdata, o_lat);
            end
            n_cmp++;
            if (o_nrd !== 0 || o_nwr !== 0) begin
                n_bad++;
                $display("FAIL err_mem[%0d] got rd=%0d wr=%0d exp 0 0", i, o_nrd, o_nwr);
            end
        end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 2'b10, 1'b0, 32'd36, 32'hDEAD_BEEF);
        n_cmp++; if (o_nwr !== 1 || o_nrd !== 0) begin n_bad++; $display("FAIL stw_mem_ops got rd=%0d wr=%0d exp rd=0 wr=1", o_nrd, o_nwr); end
        n_cmp++; if (o_waddr !== 32'd36 || o_wword !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL stw_write got addr=%h data=%h exp 00000024 deadbeef", o_waddr, o_wword); end
        n_cmp++; if (o_lat !== 2 || o_err !== 1'b0) begin n_bad++; $display("FAIL stw_resp got lat=%0d err=%b exp 2 0", o_lat, o_err); end
        n_cmp++; if (o_rdy_hi !== 1'b0) begin n_bad++; $display("FAIL stw_ready_busy got %b exp 0", o_rdy_hi); end
        issue(1'b0, 2'b10, 1'b0, 32'd36, 32'h0);
        n_cmp++; if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin n_bad++; $display("FAIL ldw36 got rdata=%h err=%b exp deadbeef 0", o_rdata, o_err); end
        n_cmp++; if (o_rdy_hi !== 1'b0) begin n_bad++; $display("FAIL ldw36_ready_busy got %b exp 0", o_rdy_hi); end
    endtask

    task automatic test_reset_midop;
        int nw, nr;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd8; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rmid_in_rmw_rd got mem_read=%b exp 1", mem_read); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_read, mem_write} !== 2'b00 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL rmid_drop got rw=%b addr=%h exp 00 0", {mem_read, mem_write}, mem_addr); end
        nw = 0; nr = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_write) nw++;
            if (resp_valid) nr++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mem_write) nw++;
            if (resp_valid) nr++;
        end
        n_cmp++; if (nw !== 0 || nr !== 0) begin n_bad++; $display("FAIL rmid_quiet got writes=%0d resps=%0d exp 0 0", nw, nr); end
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        n_cmp++; if (o_rdata !== 32'h1 || o_err !== 1'b0) begin n_bad++; $display("FAIL rmid_word8 got rdata=%h err=%b exp 00000001 0", o_rdata, o_err); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_subword_loads();
        test_errors();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
